// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity codes, FSM states
// and the 3-sample majority helper.
package uart_pkg;

  localparam int PAR_NONE  = 0;
  localparam int PAR_ODD   = 1;
  localparam int PAR_EVEN  = 2;
  localparam int DBITS_MAX = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRKWAIT
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Line synchroniser, falling-edge detect, per-bit timer and 3-sample majority vote
// centred on the middle of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int NT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  input  logic clr,
  output logic rxd_s,
  output logic fall_edge,
  output logic sample_vld,
  output logic sample_bit,
  output logic bit_end
);

  localparam int TW = $clog2(NT);
  localparam logic [TW-1:0] T_LAST = TW'(NT - 1);
  localparam logic [TW-1:0] T_VOTE = TW'(NT / 2 + 1);

  logic [1:0]    sync_reg;
  logic          prev_reg;
  logic [TW-1:0] cb_tact_reg;
  logic [TW-1:0] cb_tact_next;
  logic [1:0]    early_smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      prev_reg    <= 1'b1;
      cb_tact_reg <= '0;
    end else begin
      sync_reg    <= {sync_reg[0], rxd};
      prev_reg    <= sync_reg[1];
      cb_tact_reg <= cb_tact_next;
    end
  end

  // The first two votes are stored; the third is the live synchronised line.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_smp
      localparam logic [TW-1:0] T_CAP = TW'(NT / 2 - 1 + gi);
      logic smp_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          smp_reg <= 1'b1;
        else if (cb_tact_reg == T_CAP)
          smp_reg <= sync_reg[1];
      end
      assign early_smp[gi] = smp_reg;
    end
  endgenerate

  always_comb begin
    bit_end      = (cb_tact_reg == T_LAST);
    cb_tact_next = (clr || bit_end) ? '0 : cb_tact_reg + TW'(1);
  end

  assign rxd_s      = sync_reg[1];
  assign fall_edge  = prev_reg & ~sync_reg[1];
  assign sample_vld = (cb_tact_reg == T_VOTE);
  assign sample_bit = majority3(early_smp[0], early_smp[1], sync_reg[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, data shifter, error/break detection and a
// valid/ready hand-off of each completed word to the consumer.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int FCLK     = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DBITS    = 8,
  parameter int PARITY   = PAR_NONE,
  parameter int STOPBITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  output logic [DBITS-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun_err,
  output logic             brk
);

  localparam int NT = FCLK / BAUD;
  localparam int CW = $clog2(DBITS + 1);
  localparam logic [CW-1:0] CNT_DATA_LAST = CW'(DBITS);
  localparam logic [CW-1:0] CNT_STOP_LAST = CW'(STOPBITS - 1);
  localparam logic          ODD_FLIP      = (PARITY == PAR_ODD);
  localparam logic          HAS_PARITY    = (PARITY != PAR_NONE);

  rx_state_t        state_reg, state_next;
  logic [CW-1:0]    bit_cnt_reg;
  logic [DBITS-1:0] shift_reg;
  logic             par_err_reg, fe_acc_reg, any_one_reg;
  logic             done_reg, frame_err_reg, parity_err_reg, brk_reg, overrun_reg;
  logic [DBITS-1:0] rx_data_reg;
  logic             rx_valid_reg;

  logic rxd_s, fall_edge, sample_vld, sample_bit, bit_end;
  logic start_det, last_stop_smp, is_brk, frame_bad;

  uart_bit_timer #(.NT(NT)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .clr        (start_det),
    .rxd_s      (rxd_s),
    .fall_edge  (fall_edge),
    .sample_vld (sample_vld),
    .sample_bit (sample_bit),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (fall_edge) state_next = ST_START;
      ST_START: begin
        if (sample_vld && sample_bit) state_next = ST_IDLE;
        else if (bit_end)             state_next = ST_DATA;
      end
      ST_DATA:
        if (bit_end && bit_cnt_reg == CNT_DATA_LAST)
          state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY:  if (bit_end) state_next = ST_STOP;
      ST_STOP:    if (last_stop_smp) state_next = is_brk ? ST_BRKWAIT : ST_IDLE;
      ST_BRKWAIT: if (rxd_s) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Completion is decided at the vote of the last stop bit, not at the bit end.
  always_comb begin
    busy          = (state_reg != ST_IDLE);
    start_det     = (state_reg == ST_IDLE) && fall_edge;
    last_stop_smp = (state_reg == ST_STOP) && sample_vld && (bit_cnt_reg == CNT_STOP_LAST);
    is_brk        = ~any_one_reg & ~sample_bit;
    frame_bad     = fe_acc_reg | ~sample_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      fe_acc_reg  <= 1'b0;
      any_one_reg <= 1'b0;
    end else if (start_det) begin
      bit_cnt_reg <= '0;
      par_err_reg <= 1'b0;
      fe_acc_reg  <= 1'b0;
      any_one_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_DATA: begin
          if (sample_vld) begin
            shift_reg   <= {sample_bit, shift_reg[DBITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
            any_one_reg <= any_one_reg | sample_bit;
          end else if (bit_end && bit_cnt_reg == CNT_DATA_LAST) begin
            bit_cnt_reg <= '0;
          end
        end
        ST_PARITY: begin
          if (sample_vld) begin
            par_err_reg <= sample_bit ^ (^shift_reg) ^ ODD_FLIP;
            any_one_reg <= any_one_reg | sample_bit;
          end
        end
        ST_STOP: begin
          if (sample_vld) begin
            fe_acc_reg  <= fe_acc_reg | ~sample_bit;
            any_one_reg <= any_one_reg | sample_bit;
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status pulses in the completion cycle; the word hand-off follows one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      brk_reg        <= 1'b0;
      overrun_reg    <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
    end else begin
      done_reg       <= last_stop_smp & ~is_brk;
      frame_err_reg  <= last_stop_smp & frame_bad;
      parity_err_reg <= last_stop_smp & ~is_brk & par_err_reg & HAS_PARITY;
      brk_reg        <= last_stop_smp & is_brk;
      overrun_reg    <= done_reg & rx_valid_reg & ~rx_ready;
      if (done_reg && (!rx_valid_reg || rx_ready)) begin
        rx_data_reg  <= shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign frame_err   = frame_err_reg;
  assign parity_err  = parity_err_reg;
  assign overrun_err = overrun_reg;
  assign brk         = brk_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised frames into an 8N1 and a 7E1 receiver; expectations are
// derived from the transmitted line levels by a simple frame model.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int FCLK = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int NT   = FCLK / BAUD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_a = 1'b1, rx_ready_a = 1'b1;
  logic rxd_b = 1'b1, rx_ready_b = 1'b1;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic rx_valid_a, busy_a, frame_err_a, parity_err_a, overrun_err_a, brk_a;
  logic rx_valid_b, busy_b, frame_err_b, parity_err_b, overrun_err_b, brk_b;

  always #5 clk = ~clk;

  uart_rx_param #(.FCLK(FCLK), .BAUD(BAUD), .DBITS(8), .PARITY(PAR_NONE), .STOPBITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .busy(busy_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
    .overrun_err(overrun_err_a), .brk(brk_a)
  );

  uart_rx_param #(.FCLK(FCLK), .BAUD(BAUD), .DBITS(7), .PARITY(PAR_EVEN), .STOPBITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .busy(busy_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
    .overrun_err(overrun_err_b), .brk(brk_b)
  );

  // Scoreboard: accepted words and pulse-cycle counts per receiver.
  logic [8:0] got_a [0:63];
  logic [8:0] got_b [0:63];
  int got_n_a = 0, fe_a = 0, pe_a = 0, ov_a = 0, bk_a = 0;
  int got_n_b = 0, fe_b = 0, pe_b = 0, ov_b = 0, bk_b = 0;

  always @(negedge clk) begin
    if (rx_valid_a && rx_ready_a) begin
      if (got_n_a < 64) got_a[got_n_a] = {1'b0, rx_data_a};
      got_n_a++;
    end
    if (rx_valid_b && rx_ready_b) begin
      if (got_n_b < 64) got_b[got_n_b] = {2'b00, rx_data_b};
      got_n_b++;
    end
    fe_a += frame_err_a ? 1 : 0;  pe_a += parity_err_a ? 1 : 0;
    ov_a += overrun_err_a ? 1 : 0; bk_a += brk_a ? 1 : 0;
    fe_b += frame_err_b ? 1 : 0;  pe_b += parity_err_b ? 1 : 0;
    ov_b += overrun_err_b ? 1 : 0; bk_b += brk_b ? 1 : 0;
  end

  int checks = 0, errors = 0;
  int s_got, s_fe, s_pe, s_ov, s_bk;
  int lat = -1;
  logic [15:0] lv;
  int len;
  logic [8:0] d;
  bit flip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line levels of one frame, start bit first.
  task automatic build_frame(input logic [8:0] data, input int dbits, input int par,
                             input bit flip_par, input bit stop_zero,
                             output logic [15:0] lvl, output int n);
    logic x;
    x = 1'b0;
    n = 0;
    lvl = '1;
    lvl[n] = 1'b0; n++;
    for (int i = 0; i < dbits; i++) begin
      lvl[n] = data[i]; x ^= data[i]; n++;
    end
    if (par != PAR_NONE) begin
      lvl[n] = x ^ (par == PAR_ODD) ^ flip_par; n++;
    end
    lvl[n] = ~stop_zero; n++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_line(input bit to_b, input logic [15:0] lvl, input int n);
    for (int i = 0; i < n; i++) begin
      if (to_b) rxd_b = lvl[i]; else rxd_a = lvl[i];
      idle(NT);
    end
  endtask

  task automatic snap_a();
    s_got = got_n_a; s_fe = fe_a; s_pe = pe_a; s_ov = ov_a; s_bk = bk_a;
  endtask

  task automatic snap_b();
    s_got = got_n_b; s_fe = fe_b; s_pe = pe_b; s_ov = ov_b; s_bk = bk_b;
  endtask

  task automatic check_a(input string tag, input int words, input logic [8:0] data,
                         input int fe, input int pe, input int ov, input int bk);
    chk({tag, ".words"}, got_n_a - s_got, words);
    if (words > 0) chk({tag, ".data"}, got_a[s_got], data);
    chk({tag, ".frame_err"}, fe_a - s_fe, fe);
    chk({tag, ".parity_err"}, pe_a - s_pe, pe);
    chk({tag, ".overrun"}, ov_a - s_ov, ov);
    chk({tag, ".brk"}, bk_a - s_bk, bk);
  endtask

  task automatic check_b(input string tag, input logic [8:0] data, input int pe);
    chk({tag, ".words"}, got_n_b - s_got, 1);
    chk({tag, ".data"}, got_b[s_got], data);
    chk({tag, ".frame_err"}, fe_b - s_fe, 0);
    chk({tag, ".parity_err"}, pe_b - s_pe, pe);
    chk({tag, ".brk"}, bk_b - s_bk, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    chk("rst.a_flags", {26'd0, busy_a, rx_valid_a, frame_err_a, parity_err_a, overrun_err_a, brk_a}, 0);
    chk("rst.a_data", rx_data_a, 0);
    chk("rst.b_flags", {26'd0, busy_b, rx_valid_b, frame_err_b, parity_err_b, overrun_err_b, brk_b}, 0);
    rst_n = 1'b1;
    idle(4);

    // 8N1 0xA5 then 0x3C back to back, with latency measurement on the first
    snap_a();
    build_frame(9'hA5, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    fork
      send_line(1'b0, lv, len);
      for (int c = 1; c <= 400 && lat < 0; c++) begin
        @(posedge clk); #1;
        if (rx_valid_a === 1'b1) lat = c - 1;
      end
    join
    build_frame(9'h3C, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    send_line(1'b0, lv, len);
    idle(2 * NT);
    chk("latency", lat, 2 + (1 + 8 + 0 + 1 - 1) * NT + NT / 2 + 3);
    check_a("a5", 2, 9'hA5, 0, 0, 0, 0);
    chk("3c.data", got_a[s_got + 1], 9'h3C);

    // Random 8N1 words with random inter-frame gaps
    for (int k = 0; k < 6; k++) begin
      snap_a();
      d = 9'($urandom_range(0, 255));
      build_frame(d, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
      send_line(1'b0, lv, len);
      idle(2 * NT + $urandom_range(0, 5));
      check_a($sformatf("rnd%0d", k), 1, d, 0, 0, 0, 0);
    end

    // Stop bit low, then line high: word delivered with frame_err; next frame clean
    snap_a();
    build_frame(9'hC3, 8, PAR_NONE, 1'b0, 1'b1, lv, len);
    send_line(1'b0, lv, len);
    rxd_a = 1'b1;
    idle(2 * NT);
    check_a("ferr", 1, 9'hC3, 1, 0, 0, 0);
    snap_a();
    build_frame(9'h5A, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    send_line(1'b0, lv, len);
    idle(2 * NT);
    check_a("after_ferr", 1, 9'h5A, 0, 0, 0, 0);

    // False start: 5 clocks low
    snap_a();
    rxd_a = 1'b0;
    idle(5);
    rxd_a = 1'b1;
    chk("fstart.busy_hi", busy_a, 1);
    idle(20);
    chk("fstart.busy_lo", busy_a, 0);
    idle(2 * NT);
    check_a("fstart", 0, 9'h0, 0, 0, 0, 0);

    // One-clock glitch at the centre of data bit 2 of 0x55
    snap_a();
    build_frame(9'h55, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    for (int i = 0; i < len; i++) begin
      rxd_a = lv[i];
      if (i == 3) begin
        idle(9);
        rxd_a = ~lv[i];
        idle(1);
        rxd_a = lv[i];
        idle(NT - 10);
      end else begin
        idle(NT);
      end
    end
    idle(2 * NT);
    check_a("glitch", 1, 9'h55, 0, 0, 0, 0);

    // Overrun: consumer stalled across two frames
    rx_ready_a = 1'b0;
    snap_a();
    build_frame(9'h11, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    send_line(1'b0, lv, len);
    build_frame(9'h22, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    send_line(1'b0, lv, len);
    idle(2 * NT);
    check_a("ovr", 0, 9'h0, 0, 0, 1, 0);
    chk("ovr.valid", rx_valid_a, 1);
    chk("ovr.data_kept", rx_data_a, 8'h11);
    rx_ready_a = 1'b1;
    idle(2);
    chk("ovr.drain_words", got_n_a - s_got, 1);
    chk("ovr.drain_data", got_a[s_got], 9'h11);
    chk("ovr.valid_clr", rx_valid_a, 0);

    // Break: three frame times low, then recovery
    snap_a();
    rxd_a = 1'b0;
    idle(30 * NT);
    chk("brk.busy", busy_a, 1);
    rxd_a = 1'b1;
    idle(2 * NT);
    check_a("brk", 0, 9'h0, 1, 0, 0, 1);
    chk("brk.idle", busy_a, 0);
    snap_a();
    d = 9'($urandom_range(1, 255));
    build_frame(d, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    send_line(1'b0, lv, len);
    idle(2 * NT);
    check_a("after_brk", 1, d, 0, 0, 0, 0);

    // 7E1: 0x41 with wrong parity, then random words with random parity faults
    snap_b();
    build_frame(9'h41, 7, PAR_EVEN, 1'b1, 1'b0, lv, len);
    send_line(1'b1, lv, len);
    idle(2 * NT);
    check_b("7e1_41", 9'h41, 1);
    for (int k = 0; k < 4; k++) begin
      snap_b();
      d = 9'($urandom_range(0, 127));
      flip = 1'($urandom_range(0, 1));
      build_frame(d, 7, PAR_EVEN, flip, 1'b0, lv, len);
      send_line(1'b1, lv, len);
      idle(2 * NT);
      check_b($sformatf("7e1_rnd%0d", k), d, flip ? 1 : 0);
    end

    // Reset in the middle of the data bits, then a clean 0x99
    snap_a();
    rxd_a = 1'b0;
    repeat (4 * NT + 5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.flags", {26'd0, busy_a, rx_valid_a, frame_err_a, parity_err_a, overrun_err_a, brk_a}, 0);
    chk("rstmid.data", rx_data_a, 0);
    rxd_a = 1'b1;
    @(posedge clk); #1;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    build_frame(9'h99, 8, PAR_NONE, 1'b0, 1'b0, lv, len);
    send_line(1'b0, lv, len);
    idle(2 * NT);
    check_a("rstmid", 1, 9'h99, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
